// File: rtl/ising_phase_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : ising_phase_sampler
//  Purpose  : Runs one measurement of the coupled oscillator array. It holds
//             the array's oscillator reset low for a fixed time, lets the
//             array settle, then counts how often each spin's phase matches
//             the reference oscillator over a programmable sampling window.
//             Each per-spin match count is reduced to one spin bit, and the
//             raw counts stay readable afterwards.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1          AXI clock
//    axi_rstn       in   1          asynchronous active-low reset
//    start          in   1          begin a run (accepted in IDLE/DONE only)
//    abort          in   1          cancel a run (acts in RESET/SETTLE/SAMPLE)
//    settle_cycles  in   CNT_W      settle length, latched when start is taken
//    sample_cycles  in   CNT_W      sample window L, latched; 0 behaves as 1
//    phase_in       in   N          asynchronous spin phase outputs
//    ref_in         in   1          asynchronous reference oscillator phase
//    ising_rstn     out  1          registered oscillator reset to the array
//    busy           out  1          run in progress (RESET/SETTLE/SAMPLE)
//    done           out  1          run complete, results valid
//    spins          out  N          spins[i]=1 when spin i is in phase with ref
//    rd_idx         in   IDX_W      match counter select for readback
//    rd_count       out  CNT_W      match counter rd_idx; 0 when rd_idx >= N
// ============================================================================
module ising_phase_sampler #(
    parameter int N           = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 4,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             axi_rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0] sample_cycles,
    input  logic [N-1:0]     phase_in,
    input  logic             ref_in,
    output logic             ising_rstn,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     spins,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count
);

    // The state timer holds "clocks remaining minus one", so a value of zero
    // means the current edge is the last one spent in the state.
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers. The ring oscillators are unrelated to clk, so
    // every phase bit goes through its own flop chain before it is compared.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N-1:0] ph_sync_q;
    logic [SYNC_STAGES-1:0][N-1:0] ph_sync_d;
    logic [SYNC_STAGES-1:0]        rf_sync_q;
    logic [SYNC_STAGES-1:0]        rf_sync_d;
    logic [N-1:0]                  ps;
    logic                          rs;

    always_comb begin
        ph_sync_d = {ph_sync_q[SYNC_STAGES-2:0], phase_in};
        rf_sync_d = {rf_sync_q[SYNC_STAGES-2:0], ref_in};
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            ph_sync_q <= '0;
            rf_sync_q <= '0;
        end else begin
            ph_sync_q <= ph_sync_d;
            rf_sync_q <= rf_sync_d;
        end
    end

    assign ps = ph_sync_q[SYNC_STAGES-1];
    assign rs = rf_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Run control registers
    // ------------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] timer_q,      timer_d;
    logic [CNT_W-1:0] settle_q,     settle_d;
    logic [CNT_W-1:0] len_q,        len_d;
    logic [N-1:0]     spins_q,      spins_d;
    logic             ising_rstn_q, ising_rstn_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    // Counter control decoded by the FSM
    logic             cnt_clr;
    logic             cnt_acc;

    // ------------------------------------------------------------------------
    // Per-spin match counters. cnt_inc is the count including the current
    // clock's comparison; the spin decision on the final SAMPLE edge uses it
    // so that the last sample is not lost.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] match_cnt_q [N];
    logic [CNT_W-1:0] match_cnt_d [N];
    logic [CNT_W-1:0] cnt_inc     [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_inc[i] = match_cnt_q[i] + {{(CNT_W-1){1'b0}}, (ps[i] ~^ rs)};
            if (cnt_clr) begin
                match_cnt_d[i] = '0;
            end else if (cnt_acc) begin
                match_cnt_d[i] = cnt_inc[i];
            end else begin
                match_cnt_d[i] = match_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int i = 0; i < N; i++) begin
                match_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                match_cnt_q[i] <= match_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            settle_q     <= '0;
            len_q        <= '0;
            spins_q      <= '0;
            ising_rstn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            settle_q     <= settle_d;
            len_q        <= len_d;
            spins_q      <= spins_d;
            ising_rstn_q <= ising_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state, timer and counter control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        len_d    = len_q;
        spins_d  = spins_q;
        cnt_clr  = 1'b0;
        cnt_acc  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RESET;
                    timer_d  = RST_LOAD;
                    settle_d = settle_cycles;
                    // A zero-length window still takes one sample.
                    len_d    = (sample_cycles == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                                     : sample_cycles;
                    cnt_clr  = 1'b1;
                end
            end

            S_RESET: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else if (timer_q == '0) begin
                    if (settle_q == '0) begin
                        state_d = S_SAMPLE;
                        timer_d = len_q - 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        timer_d = settle_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = S_SAMPLE;
                    timer_d = len_q - 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_acc = 1'b1;
                    if (timer_q == '0) begin
                        state_d = S_DONE;
                        // Strict majority: exactly half the window is a 0.
                        for (int i = 0; i < N; i++) begin
                            spins_d[i] = (cnt_inc[i] > (len_q >> 1));
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they line up with
    // the state register rather than trailing it by a clock.
    // ------------------------------------------------------------------------
    always_comb begin
        ising_rstn_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE) ||
                       (state_d == S_DONE);
        busy_d       = (state_d == S_RESET) || (state_d == S_SETTLE) ||
                       (state_d == S_SAMPLE);
        done_d       = (state_d == S_DONE);
    end

    assign ising_rstn = ising_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign spins      = spins_q;

    // ------------------------------------------------------------------------
    // Counter readback. Out-of-range selects (possible when N is not a power
    // of two) read as zero.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_count = match_cnt_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ising_phase_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ising_phase_sampler
//  Purpose  : Self-checking bench for ising_phase_sampler (N=5). Inputs are
//             recorded edge by edge; expected outputs come from a run model
//             that places the RESET/SETTLE/SAMPLE windows by arithmetic on
//             the start edge and counts matches over the recorded history.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ising_phase_sampler;

    localparam int N     = 5;
    localparam int CNT_W = 16;
    localparam int S     = 2;
    localparam int RST   = 4;
    localparam int IDXW  = $clog2(N);
    localparam int HMAX  = 32768;

    logic             clk = 1'b0;
    logic             axi_rstn;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] sample_cycles;
    logic [N-1:0]     phase_in;
    logic             ref_in;
    logic             ising_rstn;
    logic             busy;
    logic             done;
    logic [N-1:0]     spins;
    logic [IDXW-1:0]  rd_idx;
    logic [CNT_W-1:0] rd_count;

    ising_phase_sampler #(
        .N          (N),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(S),
        .RST_CYCLES (RST)
    ) dut (
        .clk          (clk),
        .axi_rstn     (axi_rstn),
        .start        (start),
        .abort        (abort),
        .settle_cycles(settle_cycles),
        .sample_cycles(sample_cycles),
        .phase_in     (phase_in),
        .ref_in       (ref_in),
        .ising_rstn   (ising_rstn),
        .busy         (busy),
        .done         (done),
        .spins        (spins),
        .rd_idx       (rd_idx),
        .rd_count     (rd_count)
    );

    always #20 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping and reference model state
    // ------------------------------------------------------------------------
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    logic [N-1:0] ph_hist [HMAX];
    logic         rf_hist [HMAX];

    bit           m_running = 0;   // a run is between its start edge and done
    bit           m_done    = 0;
    bit           m_valid   = 0;   // counters hold the current run's counts
    int           m_k0      = 0;   // edge that accepted start
    int           m_set     = 0;
    int           m_len     = 1;
    logic [N-1:0] m_spins   = '0;

    int           mode [N];        // 0: = ref, 1: != ref, 2: random, 3: toggle
    bit           ref_rand = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Matches counted on sample edges up to the current edge. The value the
    // design compares at edge e is the one present S edges earlier.
    function automatic int win_count(input int i);
        int lo;
        int hi;
        int c;
        lo = m_k0 + RST + m_set + 1;
        hi = m_k0 + RST + m_set + m_len;
        if (hi > cyc) hi = cyc;
        c = 0;
        for (int e = lo; e <= hi; e++) begin
            if (ph_hist[e-S][i] == rf_hist[e-S]) c++;
        end
        return c;
    endfunction

    function automatic int exp_count(input int idx);
        if (idx >= N || !m_valid) return 0;
        return win_count(idx);
    endfunction

    task automatic model_edge();
        if (m_running && abort) begin
            m_running = 0;
            m_valid   = 0;
        end else if (!m_running && start) begin
            m_running = 1;
            m_done    = 0;
            m_valid   = 1;
            m_k0      = cyc;
            m_set     = int'(settle_cycles);
            m_len     = (sample_cycles == 0) ? 1 : int'(sample_cycles);
        end else if (m_running && (cyc - m_k0 == RST + m_set + m_len)) begin
            m_running = 0;
            m_done    = 1;
            for (int i = 0; i < N; i++) begin
                m_spins[i] = (win_count(i) > m_len / 2);
            end
        end
    endtask

    task automatic drive_phase();
        ref_in = ref_rand ? 1'($urandom) : 1'b1;
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                0:       phase_in[i] = ref_in;
                1:       phase_in[i] = ~ref_in;
                2:       phase_in[i] = 1'($urandom);
                default: phase_in[i] = 1'(cyc % 2);
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [N+2:0] exp_flags;
        if (m_running) begin
            exp_flags = {(cyc - m_k0 >= RST), 1'b1, 1'b0, m_spins};
        end else if (m_done) begin
            exp_flags = {1'b1, 1'b0, 1'b1, m_spins};
        end else begin
            exp_flags = {1'b0, 1'b0, 1'b0, m_spins};
        end
        chk("rstn_busy_done_spins", 32'({ising_rstn, busy, done, spins}), 32'(exp_flags));
        for (int idx = 0; idx < (1 << IDXW); idx++) begin
            rd_idx = IDXW'(idx);
            #1;
            chk($sformatf("rd_count[%0d]", idx), 32'(rd_count), 32'(exp_count(idx)));
        end
    endtask

    // One clock: record inputs at the edge, update model, drive new phases,
    // then check on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL history: edge budget exhausted at edge %0d", cyc);
            $fatal(1, "history overflow");
        end
        ph_hist[cyc] = phase_in;
        rf_hist[cyc] = ref_in;
        if (axi_rstn) model_edge();
        #1;
        drive_phase();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic scramble_lengths();
        settle_cycles = CNT_W'($urandom);
        sample_cycles = CNT_W'($urandom);
    endtask

    task automatic async_reset();
        #1 axi_rstn = 1'b0;
        m_running = 0;
        m_done    = 0;
        m_valid   = 0;
        m_spins   = '0;
        #1;
        chk("async_rst_flags", 32'({ising_rstn, busy, done, spins}), 32'd0);
        for (int idx = 0; idx < (1 << IDXW); idx++) begin
            rd_idx = IDXW'(idx);
            #1;
            chk("async_rst_count", 32'(rd_count), 32'd0);
        end
        tick();
        tick();
        axi_rstn = 1'b1;
    endtask

    // Launch one run and follow it to completion, abort or reset.
    task automatic run(input int s, input int l, input int abort_at,
                       input bit with_start, input int pulse_at, input int reset_at);
        int t;
        settle_cycles = CNT_W'(s);
        sample_cycles = CNT_W'(l);
        start         = 1'b1;
        tick();
        start = 1'b0;
        scramble_lengths();
        t = 1;
        while (m_running && t < 5000) begin
            if (t == reset_at) begin
                async_reset();
                return;
            end
            abort = (t == abort_at);
            start = ((t == abort_at) && with_start) || (t == pulse_at);
            tick();
            abort = 1'b0;
            start = 1'b0;
            scramble_lengths();
            t++;
        end
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2,
                             input int m3, input int m4);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3; mode[4] = m4;
    endtask

    initial begin
        axi_rstn      = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        settle_cycles = '0;
        sample_cycles = '0;
        phase_in      = '0;
        ref_in        = 1'b0;
        rd_idx        = '0;
        set_modes(2, 2, 2, 2, 2);

        repeat (3) tick();
        axi_rstn = 1'b1;
        repeat (4) tick();

        // Static ref, toggling spin0 (exact tie over even window -> 0),
        // spin2 always in phase, spin3 always out of phase.
        ref_rand = 1'b0;
        set_modes(3, 2, 0, 1, 0);
        run(3, 10, -1, 1'b0, -1, -1);
        repeat (3) tick();

        // Start pulsed in SETTLE is ignored; then abort at SAMPLE clock 5.
        ref_rand = 1'b1;
        set_modes(0, 1, 2, 3, 0);
        run(5, 12, -1, 1'b0, RST + 2, -1);
        run(4, 12, RST + 4 + 5, 1'b0, -1, -1);
        repeat (3) tick();

        // Zero settle and zero sample length: one sample clock.
        set_modes(0, 1, 0, 1, 2);
        run(0, 0, -1, 1'b0, -1, -1);

        // Restart directly from DONE with a short window.
        set_modes(1, 0, 3, 2, 0);
        run(2, 4, -1, 1'b0, -1, -1);
        run(1, 7, -1, 1'b0, -1, -1);

        // Abort and start together in SAMPLE: abort wins.
        run(2, 9, RST + 2 + 3, 1'b1, -1, -1);
        repeat (2) tick();

        // Abort while IDLE / DONE has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(1, 3, -1, 1'b0, -1, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset in the middle of SAMPLE.
        run(2, 20, -1, 1'b0, -1, RST + 2 + 6);
        repeat (2) tick();

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            int s;
            int l;
            int ab;
            int gap;
            ref_rand = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) mode[i] = $urandom_range(0, 3);
            s   = $urandom_range(0, 8);
            l   = $urandom_range(0, 24);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, RST + s + l) : -1;
            run(s, l, ab, 1'($urandom), $urandom_range(1, RST + s + 2), -1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                abort = 1'($urandom);
                tick();
                abort = 1'b0;
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
